stopwatch_ctrl: RTL and testbench

Control unit that sequences the 100 Hz tick divider and owns the stopwatch time registers. Converts single-cycle button pulses into run/clear commands for the divider, counts its ticks into centiseconds, seconds, minutes and hours, and presents them to the display path. Sits between the button debouncers and the FND/display formatter, beside the divider it drives.

---
 rtl/stopwatch_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/stop/clear FSM driving the 100 Hz divider and the cs/sec/min/hour chain.
// Optional lap hold (display freeze on snapshot) is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int CS_MAX   = 100,
    parameter int SEC_MAX  = 60,
    parameter int MIN_MAX  = 60,
    parameter int HOUR_MAX = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    input  logic       i_tick,
    output logic       o_run,
    output logic       o_clear,
    output logic [1:0] o_state,
    output logic [6:0] o_cs,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_lap_active
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    localparam logic [6:0] CS_LAST   = 7'(CS_MAX - 1);
    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);

    state_t     state_q, state_d;
    logic [6:0] cs_q, cs_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic       tick_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // run_stop has priority over clear in STOP; CLEAR always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (i_btn_run_stop) begin
                    state_d = ST_RUN;
                end else if (i_btn_clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (i_btn_run_stop) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_comb begin
        o_run   = (state_q == ST_RUN);
        o_clear = (state_q == ST_CLEAR);
        o_state = state_q;
    end

    assign tick_en = (state_q == ST_RUN) && i_tick;

    always_comb begin
        cs_d   = cs_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == ST_CLEAR) begin
            cs_d   = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick_en) begin
            if (cs_q == CS_LAST) begin
                cs_d = '0;
                if (sec_q == SEC_LAST) begin
                    sec_d = '0;
                    if (min_q == MIN_LAST) begin
                        min_d  = '0;
                        hour_d = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                cs_d = cs_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q   <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            cs_q   <= cs_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_q, lap_d;
    logic [6:0] snap_cs_q, snap_cs_d;
    logic [5:0] snap_sec_q, snap_sec_d;
    logic [5:0] snap_min_q, snap_min_d;
    logic [4:0] snap_hour_q, snap_hour_d;

    // Snapshot takes the pre-tick counter values present at the capturing edge
    always_comb begin
        lap_d       = lap_q;
        snap_cs_d   = snap_cs_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        if (state_q == ST_CLEAR) begin
            lap_d       = 1'b0;
            snap_cs_d   = '0;
            snap_sec_d  = '0;
            snap_min_d  = '0;
            snap_hour_d = '0;
        end else if ((state_q == ST_RUN) && i_btn_lap) begin
            lap_d = ~lap_q;
            if (!lap_q) begin
                snap_cs_d   = cs_q;
                snap_sec_d  = sec_q;
                snap_min_d  = min_q;
                snap_hour_d = hour_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q       <= 1'b0;
            snap_cs_q   <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
        end else begin
            lap_q       <= lap_d;
            snap_cs_q   <= snap_cs_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
        end
    end

    always_comb begin
        o_lap_active = lap_q;
        o_cs         = lap_q ? snap_cs_q   : cs_q;
        o_sec        = lap_q ? snap_sec_q  : sec_q;
        o_min        = lap_q ? snap_min_q  : min_q;
        o_hour       = lap_q ? snap_hour_q : hour_q;
    end
`else
    logic unused_lap;
    assign unused_lap = i_btn_lap;

    always_comb begin
        o_lap_active = 1'b0;
        o_cs         = cs_q;
        o_sec        = sec_q;
        o_min        = min_q;
        o_hour       = hour_q;
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a full-size instance plus a reduced-modulus instance for the
// end-of-day wrap; directed steps push expected outputs, a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

    logic clk;
    logic reset;
    logic rs, clr, lap, tick;
    logic s_rs, s_tick;

    logic       m_run, m_clear, m_lap_active;
    logic [1:0] m_state;
    logic [6:0] m_cs;
    logic [5:0] m_sec, m_min;
    logic [4:0] m_hour;

    logic       s_run, s_clear, s_lap_active;
    logic [1:0] s_state;
    logic [6:0] s_cs;
    logic [5:0] s_sec, s_min;
    logic [4:0] s_hour;

    logic [29:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          passes = 0;

    stopwatch_ctrl dut (
        .clk(clk), .reset(reset),
        .i_btn_run_stop(rs), .i_btn_clear(clr), .i_btn_lap(lap), .i_tick(tick),
        .o_run(m_run), .o_clear(m_clear), .o_state(m_state),
        .o_cs(m_cs), .o_sec(m_sec), .o_min(m_min), .o_hour(m_hour),
        .o_lap_active(m_lap_active)
    );

    stopwatch_ctrl #(.CS_MAX(3), .SEC_MAX(2), .MIN_MAX(2), .HOUR_MAX(2)) dut_small (
        .clk(clk), .reset(reset),
        .i_btn_run_stop(s_rs), .i_btn_clear(1'b0), .i_btn_lap(1'b0), .i_tick(s_tick),
        .o_run(s_run), .o_clear(s_clear), .o_state(s_state),
        .o_cs(s_cs), .o_sec(s_sec), .o_min(s_min), .o_hour(s_hour),
        .o_lap_active(s_lap_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rs_v, input logic clr_v, input logic lap_v, input logic tick_v);
        rs = rs_v; clr = clr_v; lap = lap_v; tick = tick_v;
        cycle();
        rs = 1'b0; clr = 1'b0; lap = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic sstep(input logic rs_v, input logic tick_v);
        s_rs = rs_v; s_tick = tick_v;
        cycle();
        s_rs = 1'b0; s_tick = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic sel, input logic [1:0] st,
                              input logic lap_v, input int h, input int m, input int s, input int cs);
        logic [29:0] e;
        e = {sel, st, (st == 2'b01), (st == 2'b10), lap_v, 5'(h), 6'(m), 6'(s), 7'(cs)};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [29:0] e;
            logic [28:0] act;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e[29]) act = {s_state, s_run, s_clear, s_lap_active, s_hour, s_min, s_sec, s_cs};
            else       act = {m_state, m_run, m_clear, m_lap_active, m_hour, m_min, m_sec, m_cs};
            checks++;
            if (act !== e[28:0]) begin
                $display("FAIL %s: got %h expected %h (state,run,clr,lap,h,m,s,cs)", nm, act, e[28:0]);
            end else begin
                passes++;
            end
        end
    end

    initial begin
        reset = 1'b0;
        rs = 1'b0; clr = 1'b0; lap = 1'b0; tick = 1'b0;
        s_rs = 1'b0; s_tick = 1'b0;
        cycle();
        cycle();
        expect_out("reset_main", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
        expect_out("reset_small", 1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
        cycle();
        reset = 1'b1;
        cycle();

        ticks(50);
        expect_out("stop_ignores_ticks", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("run_start", 1'b0, 2'b01, 1'b0, 0, 0, 0, 0);
        ticks(150);
        expect_out("run_150_ticks", 1'b0, 2'b01, 1'b0, 0, 0, 1, 50);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("stop_at_1_50", 1'b0, 2'b00, 1'b0, 0, 0, 1, 50);
        ticks(20);
        expect_out("stop_holds_1_50", 1'b0, 2'b00, 1'b0, 0, 0, 1, 50);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(175);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("stop_at_3_25", 1'b0, 2'b00, 1'b0, 0, 0, 3, 25);

        // clear: CLEAR for one cycle (counters still old), run_stop during CLEAR ignored
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("clear_state", 1'b0, 2'b10, 1'b0, 0, 0, 3, 25);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("clear_done", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("clear_one_cycle", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("clear_in_run_ignored", 1'b0, 2'b01, 1'b0, 0, 0, 0, 5);
        ticks(1);
        expect_out("run_after_clear_req", 1'b0, 2'b01, 1'b0, 0, 0, 0, 6);

        step(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("tick_with_stop_counted", 1'b0, 2'b00, 1'b0, 0, 0, 0, 7);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("tick_with_start_ignored", 1'b0, 2'b01, 1'b0, 0, 0, 0, 7);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("rs_beats_clear", 1'b0, 2'b01, 1'b0, 0, 0, 0, 7);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("no_clear_after_both", 1'b0, 2'b01, 1'b0, 0, 0, 0, 7);

        ticks(33);
`ifdef STOPWATCH_LAP_EN
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("lap_set", 1'b0, 2'b01, 1'b1, 0, 0, 0, 40);
        ticks(30);
        expect_out("lap_hold", 1'b0, 2'b01, 1'b1, 0, 0, 0, 40);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("lap_release", 1'b0, 2'b01, 1'b0, 0, 0, 0, 70);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("lap_persists_in_stop", 1'b0, 2'b00, 1'b1, 0, 0, 0, 70);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("lap_clear_state", 1'b0, 2'b10, 1'b1, 0, 0, 0, 70);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("lap_cleared", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
`else
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("lap_ignored", 1'b0, 2'b01, 1'b0, 0, 0, 0, 40);
        ticks(30);
        expect_out("lap_live", 1'b0, 2'b01, 1'b0, 0, 0, 0, 70);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("clear_state_2", 1'b0, 2'b10, 1'b0, 0, 0, 0, 70);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("cleared_2", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
`endif

        // reduced-modulus instance: 3 cs, 2 sec, 2 min, 2 hours -> 24 ticks per day
        sstep(1'b1, 1'b0);
        expect_out("small_run", 1'b1, 2'b01, 1'b0, 0, 0, 0, 0);
        repeat (3) sstep(1'b0, 1'b1);
        expect_out("small_cs_carry", 1'b1, 2'b01, 1'b0, 0, 0, 1, 0);
        repeat (19) sstep(1'b0, 1'b1);
        expect_out("small_pre_wrap", 1'b1, 2'b01, 1'b0, 1, 1, 1, 1);
        sstep(1'b0, 1'b1);
        expect_out("small_all_max", 1'b1, 2'b01, 1'b0, 1, 1, 1, 2);
        sstep(1'b0, 1'b1);
        expect_out("small_day_wrap", 1'b1, 2'b01, 1'b0, 0, 0, 0, 0);
        sstep(1'b0, 1'b1);
        expect_out("small_after_wrap", 1'b1, 2'b01, 1'b0, 0, 0, 0, 1);

        // asynchronous reset in the middle of a run
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        #1;
        reset = 1'b0;
        expect_out("async_reset_main", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
        expect_out("async_reset_small", 1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
        cycle();
        reset = 1'b1;
        ticks(2);
        expect_out("after_reset_stop", 1'b0, 2'b00, 1'b0, 0, 0, 0, 0);

        cycle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
